// File: rtl/exec_unit.sv
// exec_unit: three-phase (IDLE -> READ -> EXEC) register-file sequencer.
// It fetches two operands from a 4 x 8-bit register file, presents them to
// an external combinational ALU, and writes the ALU result back into the
// first source register. Divide-by-zero results are replaced by a
// parameterised constant.
module exec_unit #(
    parameter logic [7:0] DIV_ZERO_RESULT = 8'hFF
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       INSTR_VALID,
    input  logic [5:0] INSTR,
    output logic       INSTR_READY,
    output logic [1:0] ALU_OPCODE,
    output logic [7:0] ALU_A,
    output logic [7:0] ALU_B,
    input  logic [7:0] ALU_RESULT,
    input  logic       LOAD_EN,
    input  logic [1:0] LOAD_ADDR,
    input  logic [7:0] LOAD_DATA,
    input  logic [1:0] RD_ADDR,
    output logic [7:0] RD_DATA,
    output logic       DONE,
    output logic       DIV_ZERO
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [5:0]  instr_r;
    logic [7:0]  regs_r [4];
    logic [1:0]  alu_opcode_r;
    logic [7:0]  alu_a_r;
    logic [7:0]  alu_b_r;
    logic        done_r;
    logic        div_zero_r;
    logic        accept_s;
    logic        div_zero_s;
    logic [7:0]  wb_data_s;

    // Ready only in IDLE and never while reset is asserted.
    assign INSTR_READY = (state_r == ST_IDLE) && RST_N;
    assign accept_s    = INSTR_VALID && INSTR_READY;

    // A divide whose registered divisor is zero writes back the fixed constant.
    assign div_zero_s  = (alu_opcode_r == 2'b11) && (alu_b_r == 8'h00);
    assign wb_data_s   = div_zero_s ? DIV_ZERO_RESULT : ALU_RESULT;

    assign ALU_OPCODE  = alu_opcode_r;
    assign ALU_A       = alu_a_r;
    assign ALU_B       = alu_b_r;
    assign DONE        = done_r;
    assign DIV_ZERO    = div_zero_r;
    assign RD_DATA     = regs_r[RD_ADDR];

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: one accept starts a fixed READ/EXEC sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: state_s = ST_EXEC;
            ST_EXEC: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath: instruction latch, direct loads, operand fetch, write-back, status pulses.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= 8'h00;
            end
            instr_r      <= 6'h00;
            alu_opcode_r <= 2'b00;
            alu_a_r      <= 8'h00;
            alu_b_r      <= 8'h00;
            done_r       <= 1'b0;
            div_zero_r   <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Load and accept may coincide; READ then sees the loaded value.
                    if (LOAD_EN) begin
                        regs_r[LOAD_ADDR] <= LOAD_DATA;
                    end
                    if (accept_s) begin
                        instr_r <= INSTR;
                    end
                end
                ST_READ: begin
                    alu_opcode_r <= instr_r[5:4];
                    alu_a_r      <= regs_r[instr_r[3:2]];
                    alu_b_r      <= regs_r[instr_r[1:0]];
                end
                ST_EXEC: begin
                    regs_r[instr_r[3:2]] <= wb_data_s;
                    done_r               <= 1'b1;
                    div_zero_r           <= div_zero_s;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Testbench for exec_unit: directed scenarios followed by random traffic,
// compared against a transaction-level reference model.
`timescale 1ns/100ps
module tb_exec_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic [5:0] instr;
    logic       instr_ready;
    logic [1:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic       load_en;
    logic [1:0] load_addr;
    logic [7:0] load_data;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       done;
    logic       div_zero;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_regs [4];
    int m_cycles_left;      // 0 = free, 2 = operand fetch next, 1 = write-back next
    int m_op, m_dst, m_src;
    int m_alu_op, m_alu_a, m_alu_b;
    int m_done, m_dz;

    exec_unit dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .INSTR_VALID(instr_valid),
        .INSTR      (instr),
        .INSTR_READY(instr_ready),
        .ALU_OPCODE (alu_opcode),
        .ALU_A      (alu_a),
        .ALU_B      (alu_b),
        .ALU_RESULT (alu_result),
        .LOAD_EN    (load_en),
        .LOAD_ADDR  (load_addr),
        .LOAD_DATA  (load_data),
        .RD_ADDR    (rd_addr),
        .RD_DATA    (rd_data),
        .DONE       (done),
        .DIV_ZERO   (div_zero)
    );

    always #5 clk = ~clk;

    // External ALU; divide by zero returns junk that the unit must discard.
    always_comb begin
        alu_result = 8'h00;
        case (alu_opcode)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: alu_result = 8'(alu_a * alu_b);
            2'b11: alu_result = (alu_b != 8'h00) ? alu_a / alu_b : 8'h5A;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int alu_ref(input int op, input int a, input int b);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return (a * b) % 256;
            default: return (b == 0) ? 255 : a / b;
        endcase
    endfunction

    // One clock cycle: drive, check ready, clock, advance model, check outputs.
    task automatic cycle(input logic rst, input logic v, input logic [5:0] ins,
                         input logic le, input logic [1:0] la, input logic [7:0] ld);
        int ready_exp;
        @(negedge clk);
        rst_n = rst; instr_valid = v; instr = ins;
        load_en = le; load_addr = la; load_data = ld;
        #1;
        ready_exp = (rst && m_cycles_left == 0) ? 1 : 0;
        check("instr_ready", int'(instr_ready), ready_exp);
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 0;
            m_cycles_left = 0;
            m_alu_op = 0; m_alu_a = 0; m_alu_b = 0;
            m_done = 0; m_dz = 0;
        end else if (m_cycles_left == 0) begin
            m_done = 0; m_dz = 0;
            if (le) m_regs[la] = int'(ld);
            if (v) begin
                m_op = int'(ins[5:4]); m_dst = int'(ins[3:2]); m_src = int'(ins[1:0]);
                m_cycles_left = 2;
            end
        end else if (m_cycles_left == 2) begin
            m_done = 0; m_dz = 0;
            m_alu_op = m_op; m_alu_a = m_regs[m_dst]; m_alu_b = m_regs[m_src];
            m_cycles_left = 1;
        end else begin
            m_regs[m_dst] = alu_ref(m_alu_op, m_alu_a, m_alu_b);
            m_done = 1;
            m_dz = (m_alu_op == 3 && m_alu_b == 0) ? 1 : 0;
            m_cycles_left = 0;
        end
        #1;
        check("done", int'(done), m_done);
        check("div_zero", int'(div_zero), m_dz);
        check("alu_opcode", int'(alu_opcode), m_alu_op);
        check("alu_a", int'(alu_a), m_alu_a);
        check("alu_b", int'(alu_b), m_alu_b);
        rd_addr = 2'($urandom_range(0, 3));
        #0.5;
        check("rd_data", int'(rd_data), m_regs[rd_addr]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 6'h00, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic load(input logic [1:0] a, input logic [7:0] d);
        cycle(1'b1, 1'b0, 6'h00, 1'b1, a, d);
    endtask

    task automatic issue(input logic [5:0] ins);
        cycle(1'b1, 1'b1, ins, 1'b0, 2'd0, 8'h00);
        idle(2);
    endtask

    // Constant expectation for a register, independent of the model.
    task automatic check_reg(input string tag, input logic [1:0] a, input int exp);
        rd_addr = a;
        #0.5;
        check(tag, int'(rd_data), exp);
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = 6'h00;
        load_en = 1'b0; load_addr = 2'd0; load_data = 8'h00; rd_addr = 2'd0;
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_cycles_left = 0; m_op = 0; m_dst = 0; m_src = 0;
        m_alu_op = 0; m_alu_a = 0; m_alu_b = 0; m_done = 0; m_dz = 0;

        // Reset, with stray valid/load that must be ignored
        cycle(1'b0, 1'b1, 6'h01, 1'b1, 2'd0, 8'h33);
        cycle(1'b0, 1'b0, 6'h00, 1'b0, 2'd0, 8'h00);
        check_reg("reset_r0", 2'd0, 0);

        // add R0,R1 with R0=5, R1=3
        load(2'd0, 8'd5);
        load(2'd1, 8'd3);
        cycle(1'b1, 1'b1, 6'b000001, 1'b0, 2'd0, 8'h00);
        cycle(1'b1, 1'b0, 6'h00, 1'b0, 2'd0, 8'h00);
        check("add_alu_a", int'(alu_a), 5);
        check("add_alu_b", int'(alu_b), 3);
        cycle(1'b1, 1'b0, 6'h00, 1'b0, 2'd0, 8'h00);
        check("add_done", int'(done), 1);
        check_reg("add_r0", 2'd0, 8);

        // div R2,R3 with R3=0
        load(2'd2, 8'd20);
        load(2'd3, 8'd0);
        issue(6'b111011);
        check("div0_flag", int'(div_zero), 1);
        check_reg("div0_r2", 2'd2, 255);
        idle(1);

        // mul R1,R1 with R1=16 wraps to 0, then sub R1,R1
        load(2'd1, 8'd16);
        issue(6'b100101);
        check_reg("mul_r1", 2'd1, 0);
        issue(6'b010101);
        check_reg("sub_r1", 2'd1, 0);

        // Back-to-back valid with loads every cycle
        load(2'd0, 8'd1);
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 1'b1, 6'b000001, 1'b1, 2'd2, 8'(8'd40 + 8'(i)));
        idle(1);
        check_reg("b2b_r2", 2'd2, 43);

        // Reset during EXEC of add R0,R1
        load(2'd0, 8'd7);
        load(2'd1, 8'd2);
        cycle(1'b1, 1'b1, 6'b000001, 1'b0, 2'd0, 8'h00);
        cycle(1'b1, 1'b0, 6'h00, 1'b0, 2'd0, 8'h00);
        cycle(1'b0, 1'b1, 6'b000001, 1'b1, 2'd3, 8'h11);
        check("rst_done", int'(done), 0);
        check_reg("rst_r0", 2'd0, 0);
        check_reg("rst_r3", 2'd3, 0);
        idle(1);

        // Load R1=9 at the same edge as accepting add R0,R1, R0=1
        load(2'd0, 8'd1);
        cycle(1'b1, 1'b1, 6'b000001, 1'b1, 2'd1, 8'd9);
        idle(2);
        check_reg("ldacc_r0", 2'd0, 10);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                  6'($urandom),
                  ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                  2'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
